// File: rtl/ls_buffer_pkg.sv
// ls_buffer_pkg: shared widths, the NoTag encoding and the LS opcode set
// used by the load/store buffer and its wake-up sub-module.
package ls_buffer_pkg;

  localparam int LSB_DEPTH  = 8;
  localparam int LSB_DATA_W = 32;
  localparam int LSB_TAG_W  = 4;
  localparam int LSB_NAME_W = 5;
  localparam int LSB_OP_W   = 6;

  typedef logic [LSB_DATA_W-1:0] DataBus;
  typedef logic [LSB_TAG_W-1:0]  TagBus;
  typedef logic [LSB_NAME_W-1:0] NameBus;
  typedef logic [LSB_OP_W-1:0]   OpBus;

  // Tag value meaning "operand data already present"
  localparam TagBus NO_TAG = '0;

  typedef enum logic [LSB_OP_W-1:0] {
    OP_LB  = 6'h20,
    OP_LH  = 6'h21,
    OP_LW  = 6'h23,
    OP_LBU = 6'h24,
    OP_LHU = 6'h25,
    OP_SB  = 6'h28,
    OP_SH  = 6'h29,
    OP_SW  = 6'h2B
  } ls_op_e;

endpackage

// File: rtl/ls_buffer_if.sv
// ls_buffer_if: dispatch, CDB and LS-issue signals of the load/store buffer.
// master = environment side (dispatcher, CDBs, LS unit), slave = the buffer.
interface ls_buffer_if
  import ls_buffer_pkg::*;
#(
  parameter int DATA_W = LSB_DATA_W,
  parameter int TAG_W  = LSB_TAG_W,
  parameter int NAME_W = LSB_NAME_W,
  parameter int OP_W   = LSB_OP_W
);
  logic              stall;
  // dispatch side
  logic              enqEn;
  logic [OP_W-1:0]   enqOp;
  logic [DATA_W-1:0] enqImm;
  logic [TAG_W-1:0]  enqTagO;
  logic [TAG_W-1:0]  enqTagT;
  logic [DATA_W-1:0] enqDataO;
  logic [DATA_W-1:0] enqDataT;
  logic [TAG_W-1:0]  enqWrtTag;
  logic [NAME_W-1:0] enqWrtName;
  logic              bufFree;
  // common data buses
  logic              aluCdbEn;
  logic [TAG_W-1:0]  aluCdbTag;
  logic [DATA_W-1:0] aluCdbData;
  logic              lsCdbEn;
  logic [TAG_W-1:0]  lsCdbTag;
  logic [DATA_W-1:0] lsCdbData;
  // LS unit side
  logic              LSreadEn;
  logic              LSworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [DATA_W-1:0] imm;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;

  modport master (
    output stall, enqEn, enqOp, enqImm, enqTagO, enqTagT, enqDataO, enqDataT,
           enqWrtTag, enqWrtName, aluCdbEn, aluCdbTag, aluCdbData,
           lsCdbEn, lsCdbTag, lsCdbData, LSreadEn,
    input  bufFree, LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode
  );

  modport slave (
    input  stall, enqEn, enqOp, enqImm, enqTagO, enqTagT, enqDataO, enqDataT,
           enqWrtTag, enqWrtName, aluCdbEn, aluCdbTag, aluCdbData,
           lsCdbEn, lsCdbTag, lsCdbData, LSreadEn,
    output bufFree, LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode
  );

endinterface

// File: rtl/ls_buffer_entry_wake.sv
// ls_buffer_entry_wake: compares one operand tag against both CDBs and
// returns the tag/data that operand holds after this cycle. ALU bus wins
// if both buses hit (cannot happen legally, but keeps the mux defined).
module ls_buffer_entry_wake
  import ls_buffer_pkg::*;
#(
  parameter int DATA_W = LSB_DATA_W,
  parameter int TAG_W  = LSB_TAG_W
) (
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_aluEn,
  input  logic [TAG_W-1:0]  i_aluTag,
  input  logic [DATA_W-1:0] i_aluData,
  input  logic              i_lsEn,
  input  logic [TAG_W-1:0]  i_lsTag,
  input  logic [DATA_W-1:0] i_lsData,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);

  logic w_pending;
  logic w_aluHit;
  logic w_lsHit;

  assign w_pending = (i_tag != TAG_W'(NO_TAG));
  assign w_aluHit  = w_pending && i_aluEn && (i_tag == i_aluTag);
  assign w_lsHit   = w_pending && i_lsEn  && (i_tag == i_lsTag);

  // Select captured broadcast data and clear the tag on a hit
  always_comb begin
    o_tag  = i_tag;
    o_data = i_data;
    if (w_aluHit) begin
      o_tag  = TAG_W'(NO_TAG);
      o_data = i_aluData;
    end else if (w_lsHit) begin
      o_tag  = TAG_W'(NO_TAG);
      o_data = i_lsData;
    end
  end

endmodule

// File: rtl/ls_buffer.sv
// ls_buffer: in-order load/store queue between dispatch and the LS unit.
// Entries wait in a circular buffer until both operand tags clear (CDB
// wake-up), then issue strictly from the head when LS is ready.
// Optional: define LSBUF_BYPASS_EN to let the head issue in the same cycle
// a CDB broadcast supplies its last missing operand.
module ls_buffer
  import ls_buffer_pkg::*;
#(
  parameter int DEPTH  = LSB_DEPTH,
  parameter int DATA_W = LSB_DATA_W,
  parameter int TAG_W  = LSB_TAG_W,
  parameter int NAME_W = LSB_NAME_W,
  parameter int OP_W   = LSB_OP_W
) (
  input logic        clk,
  input logic        rst,
  ls_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // queue control
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_countNext;
  logic [DEPTH-1:0]  r_valid;
  logic              r_bufFree;

  // entry storage
  logic [TAG_W-1:0]  r_tagO  [DEPTH];
  logic [TAG_W-1:0]  r_tagT  [DEPTH];
  logic [DATA_W-1:0] r_dataO [DEPTH];
  logic [DATA_W-1:0] r_dataT [DEPTH];
  logic [DATA_W-1:0] r_imm   [DEPTH];
  logic [OP_W-1:0]   r_op    [DEPTH];
  logic [TAG_W-1:0]  r_wtag  [DEPTH];
  logic [NAME_W-1:0] r_wname [DEPTH];

  // per-entry operand state after this cycle's CDB capture
  logic [TAG_W-1:0]  w_tagONext  [DEPTH];
  logic [TAG_W-1:0]  w_tagTNext  [DEPTH];
  logic [DATA_W-1:0] w_dataONext [DEPTH];
  logic [DATA_W-1:0] w_dataTNext [DEPTH];

  // incoming operands after dispatch-time capture
  logic [TAG_W-1:0]  w_enqTagO;
  logic [TAG_W-1:0]  w_enqTagT;
  logic [DATA_W-1:0] w_enqDataO;
  logic [DATA_W-1:0] w_enqDataT;

  // head view used by the issue decision
  logic [TAG_W-1:0]  w_hdTagO;
  logic [TAG_W-1:0]  w_hdTagT;
  logic [DATA_W-1:0] w_hdDataO;
  logic [DATA_W-1:0] w_hdDataT;

  logic              w_enq;
  logic              w_iss;

  // registered LS outputs
  logic              r_lsWorkEn;
  logic [DATA_W-1:0] r_outOpO;
  logic [DATA_W-1:0] r_outOpT;
  logic [DATA_W-1:0] r_outImm;
  logic [TAG_W-1:0]  r_outWtag;
  logic [NAME_W-1:0] r_outWname;
  logic [OP_W-1:0]   r_outOp;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    ls_buffer_entry_wake #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_wakeO (
      .i_tag     (r_tagO[g]),
      .i_data    (r_dataO[g]),
      .i_aluEn   (bus.aluCdbEn),
      .i_aluTag  (bus.aluCdbTag),
      .i_aluData (bus.aluCdbData),
      .i_lsEn    (bus.lsCdbEn),
      .i_lsTag   (bus.lsCdbTag),
      .i_lsData  (bus.lsCdbData),
      .o_tag     (w_tagONext[g]),
      .o_data    (w_dataONext[g])
    );
    ls_buffer_entry_wake #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_wakeT (
      .i_tag     (r_tagT[g]),
      .i_data    (r_dataT[g]),
      .i_aluEn   (bus.aluCdbEn),
      .i_aluTag  (bus.aluCdbTag),
      .i_aluData (bus.aluCdbData),
      .i_lsEn    (bus.lsCdbEn),
      .i_lsTag   (bus.lsCdbTag),
      .i_lsData  (bus.lsCdbData),
      .o_tag     (w_tagTNext[g]),
      .o_data    (w_dataTNext[g])
    );
  end

  // Same compare applied to the instruction arriving from dispatch
  ls_buffer_entry_wake #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_enqWakeO (
    .i_tag     (bus.enqTagO),
    .i_data    (bus.enqDataO),
    .i_aluEn   (bus.aluCdbEn),
    .i_aluTag  (bus.aluCdbTag),
    .i_aluData (bus.aluCdbData),
    .i_lsEn    (bus.lsCdbEn),
    .i_lsTag   (bus.lsCdbTag),
    .i_lsData  (bus.lsCdbData),
    .o_tag     (w_enqTagO),
    .o_data    (w_enqDataO)
  );
  ls_buffer_entry_wake #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_enqWakeT (
    .i_tag     (bus.enqTagT),
    .i_data    (bus.enqDataT),
    .i_aluEn   (bus.aluCdbEn),
    .i_aluTag  (bus.aluCdbTag),
    .i_aluData (bus.aluCdbData),
    .i_lsEn    (bus.lsCdbEn),
    .i_lsTag   (bus.lsCdbTag),
    .i_lsData  (bus.lsCdbData),
    .o_tag     (w_enqTagT),
    .o_data    (w_enqDataT)
  );

`ifdef LSBUF_BYPASS_EN
  // Head readiness looks through this cycle's CDB capture
  assign w_hdTagO  = w_tagONext[r_head];
  assign w_hdTagT  = w_tagTNext[r_head];
  assign w_hdDataO = w_dataONext[r_head];
  assign w_hdDataT = w_dataTNext[r_head];
`else
  // Head readiness uses only what is already stored
  assign w_hdTagO  = r_tagO[r_head];
  assign w_hdTagT  = r_tagT[r_head];
  assign w_hdDataO = r_dataO[r_head];
  assign w_hdDataT = r_dataT[r_head];
`endif

  // bufFree is registered, so a full buffer refuses enqueue even when the
  // head pops in the same cycle.
  assign w_enq = bus.enqEn && r_bufFree && !bus.stall;
  assign w_iss = r_valid[r_head] && (w_hdTagO == TAG_W'(NO_TAG)) &&
                 (w_hdTagT == TAG_W'(NO_TAG)) && bus.LSreadEn && !bus.stall;

  assign w_countNext = r_count + CNT_W'(w_enq) - CNT_W'(w_iss);

  // Pointer, occupancy and valid-bit bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_bufFree <= 1'b1;
    end else begin
      if (w_enq) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      if (w_iss) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      r_count   <= w_countNext;
      r_bufFree <= (w_countNext < CNT_W'(DEPTH));
    end
  end

  // Entry payload: write at tail on enqueue, otherwise track CDB wake-up
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_enq && (r_tail == PTR_W'(i))) begin
        r_tagO[i]  <= w_enqTagO;
        r_tagT[i]  <= w_enqTagT;
        r_dataO[i] <= w_enqDataO;
        r_dataT[i] <= w_enqDataT;
        r_imm[i]   <= bus.enqImm;
        r_op[i]    <= bus.enqOp;
        r_wtag[i]  <= bus.enqWrtTag;
        r_wname[i] <= bus.enqWrtName;
      end else begin
        r_tagO[i]  <= w_tagONext[i];
        r_tagT[i]  <= w_tagTNext[i];
        r_dataO[i] <= w_dataONext[i];
        r_dataT[i] <= w_dataTNext[i];
      end
    end
  end

  // Issue register: one-cycle strobe, payload held between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsWorkEn <= 1'b0;
      r_outOpO   <= '0;
      r_outOpT   <= '0;
      r_outImm   <= '0;
      r_outWtag  <= '0;
      r_outWname <= '0;
      r_outOp    <= '0;
    end else begin
      r_lsWorkEn <= w_iss;
      if (w_iss) begin
        r_outOpO   <= w_hdDataO;
        r_outOpT   <= w_hdDataT;
        r_outImm   <= r_imm[r_head];
        r_outWtag  <= r_wtag[r_head];
        r_outWname <= r_wname[r_head];
        r_outOp    <= r_op[r_head];
      end
    end
  end

  assign bus.bufFree  = r_bufFree;
  assign bus.LSworkEn = r_lsWorkEn;
  assign bus.operandO = r_outOpO;
  assign bus.operandT = r_outOpT;
  assign bus.imm      = r_outImm;
  assign bus.wrtTag   = r_outWtag;
  assign bus.wrtName  = r_outWname;
  assign bus.opCode   = r_outOp;

endmodule

// File: tb/tb_ls_buffer.sv
// tb_ls_buffer: scoreboard bench for ls_buffer. Each enqueued instruction
// pushes its expected issue payload; each LSworkEn pulse pops and compares.
module tb_ls_buffer;
  import ls_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int NAME_W = 5;
  localparam int OP_W   = 6;

`ifdef LSBUF_BYPASS_EN
  localparam int WAKE_LAT = 1;
`else
  localparam int WAKE_LAT = 2;
`endif

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] opO;
    logic [DATA_W-1:0] opT;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  wtag;
    logic [NAME_W-1:0] wname;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  ls_buffer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W), .OP_W(OP_W)) bus ();

  ls_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
              .NAME_W(NAME_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    exp_t o;
    o.op    = bus.opCode;
    o.opO   = bus.operandO;
    o.opT   = bus.operandT;
    o.imm   = bus.imm;
    o.wtag  = bus.wrtTag;
    o.wname = bus.wrtName;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.enqEn = 0; bus.enqOp = '0; bus.enqImm = '0;
    bus.enqTagO = '0; bus.enqTagT = '0; bus.enqDataO = '0; bus.enqDataT = '0;
    bus.enqWrtTag = '0; bus.enqWrtName = '0;
    bus.aluCdbEn = 0; bus.aluCdbTag = '0; bus.aluCdbData = '0;
    bus.lsCdbEn = 0; bus.lsCdbTag = '0; bus.lsCdbData = '0;
    bus.LSreadEn = 0;
  endtask

  // One dispatch cycle; optionally records the payload LS should later see
  task automatic enq(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] imm,
                     input logic [TAG_W-1:0] tO, input logic [DATA_W-1:0] dO,
                     input logic [TAG_W-1:0] tT, input logic [DATA_W-1:0] dT,
                     input logic [TAG_W-1:0] wt, input logic [NAME_W-1:0] wn,
                     input logic [DATA_W-1:0] eO, input logic [DATA_W-1:0] eT,
                     input bit push);
    bus.enqEn = 1; bus.enqOp = op; bus.enqImm = imm;
    bus.enqTagO = tO; bus.enqDataO = dO; bus.enqTagT = tT; bus.enqDataT = dT;
    bus.enqWrtTag = wt; bus.enqWrtName = wn;
    tick();
    bus.enqEn = 0;
    if (push) sb.push_back(exp_t'{op: op, opO: eO, opT: eT, imm: imm, wtag: wt, wname: wn});
  endtask

  // Advance until the next LSworkEn pulse (bounded); CDB strobes are
  // single-cycle so they drop after the first edge. Pops the expectation.
  task automatic wait_issue(input int max, output bit got, output int lat, output exp_t e);
    got = 0; lat = 0;
    while (!got && lat < max) begin
      tick();
      bus.aluCdbEn = 0; bus.lsCdbEn = 0;
      lat++;
      if (bus.LSworkEn === 1'b1) got = 1;
    end
    if (got && sb.size() > 0) e = sb.pop_front();
    else e = '1;
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_cmp++; if (bus.bufFree !== 1'b1) begin n_bad++; $display("FAIL reset_bufFree: got %b want 1", bus.bufFree); end
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL reset_workEn: got %b want 0", bus.LSworkEn); end
    n_cmp++; if (observed() !== exp_t'('0)) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", observed()); end
    @(negedge clk); rst = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.LSreadEn = 0;
    for (int i = 0; i < 3; i++)
      enq(OP_LW, 32'(i), '0, 32'h500 + 32'(i), '0, 32'h77, 4'(i + 1), 5'(i), '0, '0, 0);
    bus.LSreadEn = 1;
    tick();
    n_cmp++; if (bus.LSworkEn !== 1'b1) begin n_bad++; $display("FAIL midrst_preissue: got %b want 1", bus.LSworkEn); end
    #2 rst = 1;
    #1;
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL midrst_workEn: got %b want 0", bus.LSworkEn); end
    n_cmp++; if (bus.bufFree !== 1'b1) begin n_bad++; $display("FAIL midrst_bufFree: got %b want 1", bus.bufFree); end
    n_cmp++; if (bus.operandO !== '0) begin n_bad++; $display("FAIL midrst_operandO: got %h want 0", bus.operandO); end
    #1 rst = 0;
    seen = 0;
    repeat (5) begin tick(); if (bus.LSworkEn !== 1'b0) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_noissue: got issue=%b want 0", seen); end
    bus.LSreadEn = 0;
  endtask

  task automatic test_ready();
    bit got; int lat; exp_t e;
    bus.LSreadEn = 1;
    enq(OP_LW, 32'h4, '0, 32'h1000, '0, 32'h0, 4'd3, 5'd4, 32'h1000, 32'h0, 1);
    wait_issue(6, got, lat, e);
    n_cmp++; if (!got || observed() !== e) begin n_bad++; $display("FAIL ready_payload: got %h want %h", observed(), e); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ready_latency: got %0d want 1", lat); end
    tick();
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL ready_strobe_width: got %b want 0", bus.LSworkEn); end
    n_cmp++; if (bus.operandO !== 32'h1000) begin n_bad++; $display("FAIL ready_hold: got %h want 00001000", bus.operandO); end
  endtask

  task automatic test_wakeup();
    bit got; int lat; exp_t e;
    bus.LSreadEn = 1;
    enq(OP_SW, 32'h8, 4'd5, 32'hDEAD, '0, 32'hABCD, 4'd6, 5'd0, 32'h2000, 32'hABCD, 1);
    tick();
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL wake_blocked: got %b want 0", bus.LSworkEn); end
    bus.aluCdbEn = 1; bus.aluCdbTag = 4'd5; bus.aluCdbData = 32'h2000;
    wait_issue(8, got, lat, e);
    n_cmp++; if (!got || observed() !== e) begin n_bad++; $display("FAIL wake_payload: got %h want %h", observed(), e); end
    n_cmp++; if (lat !== WAKE_LAT) begin n_bad++; $display("FAIL wake_latency: got %0d want %0d", lat, WAKE_LAT); end
  endtask

  task automatic test_order();
    bit got; int lat; exp_t e; bit seen;
    bus.LSreadEn = 1;
    enq(OP_LB, 32'h10, 4'd7, 32'h0, '0, 32'h0, 4'd1, 5'd1, 32'h3000, 32'h0, 1);
    enq(OP_LH, 32'h14, '0, 32'h44, '0, 32'h0, 4'd2, 5'd2, 32'h44, 32'h0, 1);
    seen = 0;
    repeat (3) begin if (bus.LSworkEn !== 1'b0) seen = 1; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL order_blocked_head: got issue=%b want 0", seen); end
    bus.lsCdbEn = 1; bus.lsCdbTag = 4'd7; bus.lsCdbData = 32'h3000;
    for (int k = 0; k < 2; k++) begin
      wait_issue(8, got, lat, e);
      n_cmp++; if (!got || observed() !== e) begin n_bad++; $display("FAIL order_issue%0d: got %h want %h", k, observed(), e); end
    end
  endtask

  task automatic test_full_wrap();
    bit got; int lat; exp_t e;
    bus.LSreadEn = 0;
    for (int i = 0; i < DEPTH; i++) begin
      enq(OP_LW, 32'(i * 4), '0, 32'h100 + 32'(i), '0, 32'h200 + 32'(i), 4'(i + 1), 5'(i + 8),
          32'h100 + 32'(i), 32'h200 + 32'(i), 1);
      if (i == DEPTH - 2) begin
        n_cmp++; if (bus.bufFree !== 1'b1) begin n_bad++; $display("FAIL full_almost: got %b want 1", bus.bufFree); end
      end
    end
    n_cmp++; if (bus.bufFree !== 1'b0) begin n_bad++; $display("FAIL full_bufFree: got %b want 0", bus.bufFree); end
    enq(OP_SB, 32'hFF, '0, 32'hBAD, '0, 32'hBAD, 4'd15, 5'd31, '0, '0, 0);
    n_cmp++; if (bus.bufFree !== 1'b0) begin n_bad++; $display("FAIL full_ninth: got %b want 0", bus.bufFree); end
    bus.LSreadEn = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_issue(4, got, lat, e);
      n_cmp++; if (!got || lat != 1 || observed() !== e) begin
        n_bad++; $display("FAIL drain%0d: got %h lat %0d want %h lat 1", i, observed(), lat, e);
      end
    end
    tick();
    n_cmp++; if (bus.LSworkEn !== 1'b0 || bus.bufFree !== 1'b1) begin
      n_bad++; $display("FAIL drain_end: got workEn %b bufFree %b want 0 1", bus.LSworkEn, bus.bufFree);
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL drain_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_stall();
    bit got; int lat; exp_t e; bit seen;
    bus.LSreadEn = 0;
    enq(OP_LW, 32'h20, '0, 32'h900, '0, 32'h0, 4'd9, 5'd9, 32'h900, 32'h0, 1);
    enq(OP_LW, 32'h24, 4'd6, 32'h0, '0, 32'h0, 4'd10, 5'd10, 32'h4444, 32'h0, 1);
    bus.stall = 1; bus.LSreadEn = 1;
    bus.enqEn = 1; bus.enqOp = OP_SH; bus.enqImm = 32'h99; bus.enqTagO = '0; bus.enqTagT = '0;
    bus.enqWrtTag = 4'd11; bus.enqWrtName = 5'd11;
    bus.aluCdbEn = 1; bus.aluCdbTag = 4'd6; bus.aluCdbData = 32'h4444;
    tick();
    bus.aluCdbEn = 0; bus.enqEn = 0;
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL stall_noissue0: got %b want 0", bus.LSworkEn); end
    tick();
    n_cmp++; if (bus.LSworkEn !== 1'b0) begin n_bad++; $display("FAIL stall_noissue1: got %b want 0", bus.LSworkEn); end
    bus.stall = 0;
    for (int k = 0; k < 2; k++) begin
      wait_issue(4, got, lat, e);
      n_cmp++; if (!got || lat != 1 || observed() !== e) begin
        n_bad++; $display("FAIL stall_issue%0d: got %h lat %0d want %h lat 1", k, observed(), lat, e);
      end
    end
    seen = 0;
    repeat (4) begin tick(); if (bus.LSworkEn !== 1'b0) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stall_enq_refused: got extra issue=%b want 0", seen); end
    bus.LSreadEn = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_ready();
    test_wakeup();
    test_order();
    test_full_wrap();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
